// File: rtl/edge_detect_pkg.sv
// -----------------------------------------------------------------------------
// edge_detect_pkg
//   Shared constants and elaboration helpers for multi_edge_detect.
//   GLITCH_CNT_W / GLITCH_CNT_MAX size the per-channel aborted-transition
//   counter that exists only when MULTI_EDGE_GLITCH_STAT_EN is defined.
//   filt_len_fits() checks that the filter length can be reached by a
//   counter of the chosen width.
// -----------------------------------------------------------------------------
package edge_detect_pkg;

  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

  // The counter only has to reach FILT_LEN-1, so FILT_LEN may equal 2**cnt_w.
  function automatic bit filt_len_fits(input int filt_len, input int cnt_w);
    return (filt_len >= 1) && (filt_len <= (1 << cnt_w));
  endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// -----------------------------------------------------------------------------
// edge_filter_ch
//   One channel of multi_edge_detect: SYNC_STAGES-deep synchroniser, glitch
//   filter, filtered level and registered one-cycle rise/fall pulses.
//   Optional macro MULTI_EDGE_GLITCH_STAT_EN adds a saturating counter of
//   aborted transitions.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         detection enable; while low the level tracks silently
//   din        raw asynchronous input
//   level      filtered, synchronised level
//   pos / neg  one-cycle pulses coincident with a level change
//   glitch_cnt aborted-transition count (macro only)
// -----------------------------------------------------------------------------
module edge_filter_ch
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT_W  = 3,
  parameter int FILT_LEN    = 3,
  parameter bit POS_EN      = 1'b1,
  parameter bit NEG_EN      = 1'b1,
  parameter bit INIT        = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    din,
  output logic                    level,
  output logic                    pos,
  output logic                    neg
`ifdef MULTI_EDGE_GLITCH_STAT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pos_q, pos_d;
  logic                   neg_q, neg_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d   = cnt_q;
    level_d = level_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    if (!en) begin
      // Follow the input quietly so re-enabling never fires a stale edge.
      cnt_d   = '0;
      level_d = s;
    end else if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s;
      cnt_d   = '0;
      pos_d   = s & POS_EN;
      neg_d   = ~s & NEG_EN;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{INIT}};
      cnt_q   <= '0;
      level_q <= INIT;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  assign level = level_q;
  assign pos   = pos_q;
  assign neg   = neg_q;

`ifdef MULTI_EDGE_GLITCH_STAT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

  // A non-zero count that finds the input back at the level is an aborted
  // transition, i.e. one rejected glitch.
  always_comb begin
    glitch_d = glitch_q;
    if (en && (cnt_q != '0) && (s == level_q) && (glitch_q != GLITCH_CNT_MAX))
      glitch_d = glitch_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_q <= '0;
    else        glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: rtl/multi_edge_detect.sv
// -----------------------------------------------------------------------------
// multi_edge_detect
//   CH_NUM independent channels of synchronise + glitch-filter + edge detect,
//   intended for slow asynchronous pins such as I2C SCL/SDA.
//   Optional macro MULTI_EDGE_GLITCH_STAT_EN adds the glitch_cnt port
//   (8 bits per channel, slice [8*i+7:8*i] for channel i, saturating).
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           detection enable
//   input_signal raw asynchronous inputs, one per channel
//   level        filtered levels
//   pos / neg    one-cycle rise / fall pulses
//   any_edge     OR of all pos and neg bits (combinational)
//   glitch_cnt   per-channel aborted-transition counters (macro only)
// -----------------------------------------------------------------------------
module multi_edge_detect
  import edge_detect_pkg::*;
#(
  parameter int                CH_NUM      = 2,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILT_CNT_W  = 3,
  parameter int                FILT_LEN    = 3,
  parameter logic [CH_NUM-1:0] POS_ENABLE  = {CH_NUM{1'b1}},
  parameter logic [CH_NUM-1:0] NEG_ENABLE  = {CH_NUM{1'b1}},
  parameter logic [CH_NUM-1:0] INIT_VAL    = {CH_NUM{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [CH_NUM-1:0]                input_signal,
  output logic [CH_NUM-1:0]                level,
  output logic [CH_NUM-1:0]                pos,
  output logic [CH_NUM-1:0]                neg,
  output logic                             any_edge
`ifdef MULTI_EDGE_GLITCH_STAT_EN
  ,
  output logic [GLITCH_CNT_W*CH_NUM-1:0]   glitch_cnt
`endif
);

  if (!filt_len_fits(FILT_LEN, FILT_CNT_W)) begin : g_bad_filt_len
    $error("multi_edge_detect: FILT_LEN must be in 1..2**FILT_CNT_W");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_edge_detect: SYNC_STAGES must be at least 2");
  end
  if (CH_NUM < 1) begin : g_bad_ch
    $error("multi_edge_detect: CH_NUM must be at least 1");
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    edge_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CNT_W  (FILT_CNT_W),
      .FILT_LEN    (FILT_LEN),
      .POS_EN      (POS_ENABLE[i]),
      .NEG_EN      (NEG_ENABLE[i]),
      .INIT        (INIT_VAL[i])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (input_signal[i]),
      .level      (level[i]),
      .pos        (pos[i]),
      .neg        (neg[i])
`ifdef MULTI_EDGE_GLITCH_STAT_EN
      ,
      .glitch_cnt (glitch_cnt[GLITCH_CNT_W*i +: GLITCH_CNT_W])
`endif
    );
  end

  assign any_edge = |(pos | neg);

endmodule

// File: tb/tb_multi_edge_detect.sv
module tb_multi_edge_detect;

  typedef struct packed {
    int         cyc;
    logic [1:0] lvl;
    logic [1:0] p;
    logic [1:0] n;
  } ev_t;

  localparam logic [1:0] PM_B   = 2'b10;
  localparam logic [1:0] INIT_C = 2'b01;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [1:0] in_a, in_b, in_c;
  logic [1:0] lv_a, pos_a, neg_a, lv_b, pos_b, neg_b, lv_c, pos_c, neg_c;
  logic any_a, any_b, any_c;
`ifdef MULTI_EDGE_GLITCH_STAT_EN
  logic [15:0] gc_a, gc_b, gc_c;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  ev_t exp_q[$];
  logic [1:0] lvl_a_exp = 2'b00, lvl_b_exp = 2'b00, lvl_c_exp = INIT_C;

  always #5 clk = ~clk;

  multi_edge_detect dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .input_signal(in_a),
    .level(lv_a), .pos(pos_a), .neg(neg_a), .any_edge(any_a)
`ifdef MULTI_EDGE_GLITCH_STAT_EN
    , .glitch_cnt(gc_a)
`endif
  );

  multi_edge_detect #(.POS_ENABLE(PM_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .input_signal(in_b),
    .level(lv_b), .pos(pos_b), .neg(neg_b), .any_edge(any_b)
`ifdef MULTI_EDGE_GLITCH_STAT_EN
    , .glitch_cnt(gc_b)
`endif
  );

  multi_edge_detect #(.INIT_VAL(INIT_C)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .input_signal(in_c),
    .level(lv_c), .pos(pos_c), .neg(neg_c), .any_edge(any_c)
`ifdef MULTI_EDGE_GLITCH_STAT_EN
    , .glitch_cnt(gc_c)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    in_a = 2'b00; in_b = 2'b00; in_c = INIT_C;
    step(); step();
    checks++;
    if ({lv_a, pos_a, neg_a, any_a} !== 7'b0) begin
      failures++;
      $display("FAIL reset_a got lvl=%b pos=%b neg=%b any=%b exp all 0", lv_a, pos_a, neg_a, any_a);
    end
    checks++;
    if ({lv_c, pos_c, neg_c, any_c} !== {INIT_C, 5'b0}) begin
      failures++;
      $display("FAIL reset_c got lvl=%b pos=%b neg=%b exp lvl=%b pos=0 neg=0", lv_c, pos_c, neg_c, INIT_C);
    end
`ifdef MULTI_EDGE_GLITCH_STAT_EN
    checks++;
    if (gc_a !== 16'h0) begin
      failures++;
      $display("FAIL reset_glitch got %h exp 0000", gc_a);
    end
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({lv_a, pos_a, neg_a, lv_b, pos_b, neg_b} !== 12'b0) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got a=%b%b%b b=%b%b%b exp zero", cyc, lv_a, pos_a, neg_a, lv_b, pos_b, neg_b);
      end
    end
  endtask

  // ch0 rise then fall with default parameters: level/pos/neg after 2+3 clocks.
  task automatic test_rise_fall();
    ev_t ev;
    logic [1:0] p_e, n_e;
    in_a = 2'b01;
    exp_q.push_back('{cyc + 5, 2'b01, 2'b01, 2'b00});
    for (int i = 0; i < 18; i++) begin
      step();
      p_e = 2'b00; n_e = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front(); lvl_a_exp = ev.lvl; p_e = ev.p; n_e = ev.n;
      end
      checks++;
      if ({lv_a, pos_a, neg_a, any_a} !== {lvl_a_exp, p_e, n_e, |(p_e | n_e)}) begin
        failures++;
        $display("FAIL rise_fall cyc=%0d got lvl=%b pos=%b neg=%b any=%b exp lvl=%b pos=%b neg=%b any=%b",
                 cyc, lv_a, pos_a, neg_a, any_a, lvl_a_exp, p_e, n_e, |(p_e | n_e));
      end
      if (i == 8) begin
        in_a = 2'b00;
        exp_q.push_back('{cyc + 5, 2'b00, 2'b00, 2'b01});
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rise_fall_pending got %0d events left exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ch1: 2-clock pulse is rejected, 3-clock pulse gives pos then neg 3 apart.
  task automatic test_glitch();
    ev_t ev;
    logic [1:0] p_e, n_e;
    in_a = 2'b10;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 1) in_a = 2'b00;
      checks++;
      if ({lv_a, pos_a, neg_a} !== {lvl_a_exp, 4'b0}) begin
        failures++;
        $display("FAIL glitch_short cyc=%0d got lvl=%b pos=%b neg=%b exp lvl=%b pos=0 neg=0", cyc, lv_a, pos_a, neg_a, lvl_a_exp);
      end
    end
`ifdef MULTI_EDGE_GLITCH_STAT_EN
    checks++;
    if (gc_a !== 16'h0100) begin
      failures++;
      $display("FAIL glitch_count got %h exp 0100", gc_a);
    end
`endif
    in_a = 2'b10;
    exp_q.push_back('{cyc + 5, 2'b10, 2'b10, 2'b00});
    exp_q.push_back('{cyc + 8, 2'b00, 2'b00, 2'b10});
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 2) in_a = 2'b00;
      p_e = 2'b00; n_e = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front(); lvl_a_exp = ev.lvl; p_e = ev.p; n_e = ev.n;
      end
      checks++;
      if ({lv_a, pos_a, neg_a, any_a} !== {lvl_a_exp, p_e, n_e, |(p_e | n_e)}) begin
        failures++;
        $display("FAIL glitch_long cyc=%0d got lvl=%b pos=%b neg=%b any=%b exp lvl=%b pos=%b neg=%b",
                 cyc, lv_a, pos_a, neg_a, any_a, lvl_a_exp, p_e, n_e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL glitch_pending got %0d events left exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // POS_ENABLE=2'b10: ch0 level follows, pos[0] masked, neg[0] pulses.
  task automatic test_pos_mask();
    ev_t ev;
    logic [1:0] p_e, n_e;
    in_b = 2'b01;
    exp_q.push_back('{cyc + 5, 2'b01, 2'b01 & PM_B, 2'b00});
    for (int i = 0; i < 16; i++) begin
      step();
      p_e = 2'b00; n_e = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front(); lvl_b_exp = ev.lvl; p_e = ev.p; n_e = ev.n;
      end
      checks++;
      if ({lv_b, pos_b, neg_b, any_b} !== {lvl_b_exp, p_e, n_e, |(p_e | n_e)}) begin
        failures++;
        $display("FAIL pos_mask cyc=%0d got lvl=%b pos=%b neg=%b any=%b exp lvl=%b pos=%b neg=%b",
                 cyc, lv_b, pos_b, neg_b, any_b, lvl_b_exp, p_e, n_e);
      end
      if (i == 7) begin
        in_b = 2'b00;
        exp_q.push_back('{cyc + 5, 2'b00, 2'b00, 2'b01});
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pos_mask_pending got %0d events left exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // en=0: level follows after SYNC_STAGES+1 clocks without pulses.
  task automatic test_enable();
    ev_t ev;
    logic [1:0] p_e, n_e;
    en = 1'b0;
    in_a = 2'b01;
    exp_q.push_back('{cyc + 3, 2'b01, 2'b00, 2'b00});
    for (int i = 0; i < 22; i++) begin
      step();
      p_e = 2'b00; n_e = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front(); lvl_a_exp = ev.lvl; p_e = ev.p; n_e = ev.n;
      end
      checks++;
      if ({lv_a, pos_a, neg_a, any_a} !== {lvl_a_exp, p_e, n_e, |(p_e | n_e)}) begin
        failures++;
        $display("FAIL enable cyc=%0d got lvl=%b pos=%b neg=%b any=%b exp lvl=%b pos=%b neg=%b",
                 cyc, lv_a, pos_a, neg_a, any_a, lvl_a_exp, p_e, n_e);
      end
      if (i == 5) en = 1'b1;
      if (i == 11) begin
        in_a = 2'b00;
        exp_q.push_back('{cyc + 5, 2'b00, 2'b00, 2'b01});
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL enable_pending got %0d events left exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Both channels rise together and are left high for the reset test.
  task automatic test_back_to_back();
    ev_t ev;
    logic [1:0] p_e, n_e;
    in_a = 2'b11;
    exp_q.push_back('{cyc + 5, 2'b11, 2'b11, 2'b00});
    for (int i = 0; i < 9; i++) begin
      step();
      p_e = 2'b00; n_e = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front(); lvl_a_exp = ev.lvl; p_e = ev.p; n_e = ev.n;
      end
      checks++;
      if ({lv_a, pos_a, neg_a, any_a} !== {lvl_a_exp, p_e, n_e, |(p_e | n_e)}) begin
        failures++;
        $display("FAIL simultaneous cyc=%0d got lvl=%b pos=%b neg=%b any=%b exp lvl=%b pos=%b neg=%b",
                 cyc, lv_a, pos_a, neg_a, any_a, lvl_a_exp, p_e, n_e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL simultaneous_pending got %0d events left exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reset with dut_c mid-transition (cnt=2); dut_a level is 11 at that point.
  task automatic test_reset_mid();
    ev_t ev;
    logic [1:0] p_e, n_e;
    in_c = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({lv_c, pos_c, neg_c} !== {INIT_C, 4'b0}) begin
        failures++;
        $display("FAIL pre_reset_c cyc=%0d got lvl=%b pos=%b neg=%b exp lvl=%b", cyc, lv_c, pos_c, neg_c, INIT_C);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lv_c, pos_c, neg_c, any_c} !== {INIT_C, 5'b0}) begin
      failures++;
      $display("FAIL reset_mid_c got lvl=%b pos=%b neg=%b any=%b exp lvl=%b rest 0", lv_c, pos_c, neg_c, any_c, INIT_C);
    end
    checks++;
    if (lv_a !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_a got lvl=%b exp 00", lv_a);
    end
    in_a = 2'b00; in_c = INIT_C;
    lvl_a_exp = 2'b00; lvl_c_exp = INIT_C;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step();
      p_e = 2'b00; n_e = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front(); lvl_c_exp = ev.lvl; p_e = ev.p; n_e = ev.n;
      end
      checks++;
      if ({lv_c, pos_c, neg_c, any_c, lv_a, pos_a, neg_a} !== {lvl_c_exp, p_e, n_e, |(p_e | n_e), 6'b0}) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got c=%b/%b/%b a=%b/%b/%b exp c=%b/%b/%b a=00/00/00",
                 cyc, lv_c, pos_c, neg_c, lv_a, pos_a, neg_a, lvl_c_exp, p_e, n_e);
      end
      // A fresh transition must need the full filter length again.
      if (i == 8) begin
        in_c = 2'b10;
        exp_q.push_back('{cyc + 5, 2'b10, 2'b10, 2'b01});
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_pending got %0d events left exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // 300 one-clock glitches on dut_a ch0.
  task automatic test_glitch_saturate();
    int pulses = 0;
    for (int g = 0; g < 300; g++) begin
      in_a = 2'b01;
      step();
      in_a = 2'b00;
      for (int k = 0; k < 3; k++) begin
        step();
        if ((pos_a | neg_a) != 2'b00) pulses++;
      end
`ifdef MULTI_EDGE_GLITCH_STAT_EN
      if (g == 99) begin
        step(); step();
        checks++;
        if (gc_a !== 16'h0064) begin
          failures++;
          $display("FAIL glitch_100 got %h exp 0064", gc_a);
        end
      end
`endif
    end
    step(); step(); step();
    checks++;
    if (lv_a !== 2'b00 || pulses != 0) begin
      failures++;
      $display("FAIL glitch_burst got lvl=%b pulses=%0d exp lvl=00 pulses=0", lv_a, pulses);
    end
`ifdef MULTI_EDGE_GLITCH_STAT_EN
    checks++;
    if (gc_a !== 16'h00FF) begin
      failures++;
      $display("FAIL glitch_saturate got %h exp 00ff", gc_a);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rise_fall();
    test_glitch();
    test_pos_mask();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    test_glitch_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
